// File: rtl/pio_write_arbiter.sv
// pio_write_arbiter: round-robin arbiter serialising two requesters' writes onto an Avalon-MM PIO slave
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req0/req1, addr0/addr1, data0/data1  requester write requests (held until ack)
//   ack0/ack1                         one-cycle completion pulse to the served requester
//   m_address, m_chipselect, m_write_n, m_writedata, m_readdata
//                                     Avalon-MM master towards the PIO slave (zero-wait read data)
//   busy                              high whenever a transaction is in progress
//   err                               sticky read-back mismatch flag
//
// Build option: define PIO_ARB_VERIFY_EN to add a one-cycle read-back VERIFY state after each
// write; bits selected by DATA_MASK are compared and a mismatch sets err. Without it err is 0.
module pio_write_arbiter #(
    parameter logic [31:0] DATA_MASK = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        err
);
`ifdef PIO_ARB_VERIFY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, VERIFY = 2'd2, ACK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd3} state_t;
`endif
    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        cs_q, cs_d;
    logic        write_n_q, write_n_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        winner;
`ifdef PIO_ARB_VERIFY_EN
    logic        err_q, err_d;
    logic        mismatch;
    assign mismatch = (m_readdata & DATA_MASK) != (data_q & DATA_MASK);
    assign err      = err_q;
`else
    logic        unused_readdata;
    assign unused_readdata = ^(m_readdata & DATA_MASK);
    assign err             = 1'b0;
`endif
    // On a tie the requester that was not served last wins; otherwise the sole requester wins.
    assign winner = (req0 && req1) ? ~last_grant_q : req1;
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cs_d         = 1'b0;
        write_n_d    = 1'b1;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
`ifdef PIO_ARB_VERIFY_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d   = winner;
                    addr_d    = winner ? addr1 : addr0;
                    data_d    = winner ? data1 : data0;
                    cs_d      = 1'b1;
                    write_n_d = 1'b0;
                    state_d   = WRITE;
                end
            end
`ifdef PIO_ARB_VERIFY_EN
            WRITE: begin
                cs_d    = 1'b1;
                state_d = VERIFY;
            end
            VERIFY: begin
                err_d   = err_q | mismatch;
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                state_d = ACK;
            end
`else
            WRITE: begin
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                state_d = ACK;
            end
`endif
            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= 2'd0;
            data_q       <= 32'd0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
`ifdef PIO_ARB_VERIFY_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
`ifdef PIO_ARB_VERIFY_EN
            err_q        <= err_d;
`endif
        end
    end
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign m_address    = addr_q;
    assign m_writedata  = data_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = write_n_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_pio_write_arbiter.sv
// tb_pio_write_arbiter: randomized and directed self-checking bench for pio_write_arbiter
module tb_pio_write_arbiter;
    localparam logic [31:0] MASK = 32'h0000_0001;
`ifdef PIO_ARB_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    // cycle offset (from the write cycle) at which ack pulses
    localparam int NACK = VER ? 2 : 1;

    logic        clk = 1'b0, reset_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  addr0 = '0, addr1 = '0;
    logic [31:0] data0 = '0, data1 = '0, m_readdata = '0;
    logic        ack0, ack1, m_chipselect, m_write_n, busy, err;
    logic [1:0]  m_address;
    logic [31:0] m_writedata;

    pio_write_arbiter #(.DATA_MASK(MASK)) dut (
        .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // transaction-level model: p = cycles since the write cycle of the current transaction, -1 = idle
    int          p;
    bit          last, cur, m_err;
    logic [1:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        p = -1; last = 1'b1; cur = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_edge();
        if (p < 0) begin
            if (req0 || req1) begin
                cur    = (req0 && req1) ? ~last : req1;
                m_addr = cur ? addr1 : addr0;
                m_data = cur ? data1 : data0;
                p      = 0;
            end
        end else begin
            if (VER && p == 1 && ((m_readdata & MASK) != (m_data & MASK))) m_err = 1'b1;
            if (p == NACK) begin
                p = -1; last = cur;
            end else p++;
        end
    endtask

    function automatic logic [5:0] exp_ctl();
        logic cs, wn, a0, a1;
        cs = (p == 0) || (VER && p == 1);
        wn = (p != 0);
        a0 = (p == NACK) && !cur;
        a1 = (p == NACK) && cur;
        return {cs, wn, a0, a1, p >= 0, m_err};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({m_chipselect, m_write_n, ack0, ack1, busy, err} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_ctl actual=%b expected=010000", {m_chipselect, m_write_n, ack0, ack1, busy, err});
        end
        checks++;
        if ({m_address, m_writedata} !== 34'd0) begin
            failures++;
            $display("FAIL reset_dp actual=%h expected=0", {m_address, m_writedata});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({m_chipselect, m_write_n, ack0, ack1, busy, err} !== exp_ctl()) begin
            failures++;
            $display("FAIL reset_idle actual=%b expected=%b", {m_chipselect, m_write_n, ack0, ack1, busy, err}, exp_ctl());
        end
    endtask

    task automatic test_single();
        int wr_at = -1, ack_at = -1, n_wr = 0, n_a0 = 0, n_a1 = 0;
        req0 = 1'b1; addr0 = 2'd0; data0 = 32'h1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err} !== exp_ctl()) begin
                failures++;
                $display("FAIL single_ctl c=%0d actual=%b expected=%b", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, exp_ctl());
            end
            if (m_chipselect && !m_write_n) begin
                n_wr++; wr_at = c;
                checks++;
                if ({m_address, m_writedata} !== {2'd0, 32'h1}) begin
                    failures++;
                    $display("FAIL single_wrdata actual=%h expected=%h", {m_address, m_writedata}, {2'd0, 32'h1});
                end
            end
            if (ack0) begin n_a0++; ack_at = c; req0 = 1'b0; end
            if (ack1) n_a1++;
        end
        checks++;
        if (n_wr != 1 || n_a0 != 1 || n_a1 != 0) begin
            failures++;
            $display("FAIL single_counts writes=%0d ack0=%0d ack1=%0d expected 1 1 0", n_wr, n_a0, n_a1);
        end
        checks++;
        if (wr_at != 0 || ack_at - wr_at != NACK) begin
            failures++;
            $display("FAIL single_latency write_at=%0d ack_at=%0d expected 0 %0d", wr_at, ack_at, NACK);
        end
    endtask

    task automatic test_tie();
        bit order[$];
        reset_n = 1'b0; model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        req0 = 1'b1; addr0 = 2'd1; data0 = $urandom();
        req1 = 1'b1; addr1 = 2'd2; data1 = $urandom();
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {exp_ctl(), m_addr, m_data}) begin
                failures++;
                $display("FAIL tie_cycle c=%0d actual=%b_%h expected=%b_%h", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata}, exp_ctl(), {m_addr, m_data});
            end
            if (ack0) begin order.push_back(1'b0); req0 = 1'b0; end
            if (ack1) begin order.push_back(1'b1); req1 = 1'b0; end
        end
        checks++;
        if (order.size() != 2 || order[0] != 1'b0 || order[1] != 1'b1) begin
            failures++;
            $display("FAIL tie_order count=%0d first=%0d second=%0d expected 2 0 1", order.size(),
                     order.size() > 0 ? int'(order[0]) : -1, order.size() > 1 ? int'(order[1]) : -1);
        end
    endtask

    task automatic test_back_to_back();
        bit order[$];
        int last_ack = -1;
        req0 = 1'b1; addr0 = 2'd3; data0 = $urandom();
        req1 = 1'b1; addr1 = 2'd1; data1 = $urandom();
        for (int c = 0; c < 4 * (NACK + 2); c++) begin
            tick();
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {exp_ctl(), m_addr, m_data}) begin
                failures++;
                $display("FAIL b2b_cycle c=%0d actual=%b_%h expected=%b_%h", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata}, exp_ctl(), {m_addr, m_data});
            end
            if (m_chipselect && !m_write_n && last_ack >= 0) begin
                checks++;
                if (c - last_ack != 2) begin
                    failures++;
                    $display("FAIL b2b_gap write_at=%0d prev_ack_at=%0d expected gap 2", c, last_ack);
                end
            end
            if (ack0) begin order.push_back(1'b0); last_ack = c; end
            if (ack1) begin order.push_back(1'b1); last_ack = c; end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (order.size() != 4 || order[0] != 1'b0 || order[1] != 1'b1 || order[2] != 1'b0 || order[3] != 1'b1) begin
            failures++;
            $display("FAIL b2b_order count=%0d expected 4 grants ordered 0,1,0,1", order.size());
        end
    endtask

    task automatic test_drop_mid();
        int n_a1 = 0;
        req1 = 1'b1; addr1 = 2'd2; data1 = $urandom();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) req1 = 1'b0;
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {exp_ctl(), m_addr, m_data}) begin
                failures++;
                $display("FAIL drop_cycle c=%0d actual=%b_%h expected=%b_%h", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata}, exp_ctl(), {m_addr, m_data});
            end
            if (ack1) n_a1++;
        end
        checks++;
        if (n_a1 != 1) begin
            failures++;
            $display("FAIL drop_ack ack1_pulses=%0d expected=1", n_a1);
        end
    endtask

    task automatic test_reset_mid();
        int n_a0 = 0, n_a1 = 0;
        req0 = 1'b1; addr0 = 2'd3; data0 = $urandom() | 32'h8000_0000;
        tick();
        checks++;
        if ({m_chipselect, m_write_n} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_write actual=%b expected=10", {m_chipselect, m_write_n});
        end
        #1 reset_n = 1'b0;
        model_reset();
        req0 = 1'b0;
        #1;
        checks++;
        if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {6'b010000, 34'd0}) begin
            failures++;
            $display("FAIL rstmid_async actual=%b_%h expected=010000_0", {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata});
        end
        repeat (2) begin
            @(negedge clk);
            if (ack0 || ack1) n_a0++;
        end
        reset_n = 1'b1;
        req1 = 1'b1; addr1 = 2'd1; data1 = $urandom();
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {exp_ctl(), m_addr, m_data}) begin
                failures++;
                $display("FAIL rstmid_cycle c=%0d actual=%b_%h expected=%b_%h", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata}, exp_ctl(), {m_addr, m_data});
            end
            if (ack0) n_a0++;
            if (ack1) begin n_a1++; req1 = 1'b0; end
        end
        checks++;
        if (n_a0 != 0 || n_a1 != 1) begin
            failures++;
            $display("FAIL rstmid_acks aborted_acks=%0d ack1=%0d expected 0 1", n_a0, n_a1);
        end
    endtask

    task automatic test_verify();
        bit saw_read = 1'b0;
        req0 = 1'b1; addr0 = 2'd2; data0 = 32'h1; m_readdata = 32'h0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {exp_ctl(), m_addr, m_data}) begin
                failures++;
                $display("FAIL verify_cycle c=%0d actual=%b_%h expected=%b_%h", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata}, exp_ctl(), {m_addr, m_data});
            end
            if (m_chipselect && m_write_n) saw_read = 1'b1;
            if (ack0) req0 = 1'b0;
        end
        repeat (3) tick();
        checks++;
        if (err !== VER || saw_read !== VER) begin
            failures++;
            $display("FAIL verify_mismatch err=%b read_seen=%b expected %b %b", err, saw_read, VER, VER);
        end
        reset_n = 1'b0; model_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL verify_clear err=%b expected=0", err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        req0 = 1'b1; data0 = 32'hFFFF_FFFF; m_readdata = 32'h1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack0) req0 = 1'b0;
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL verify_masked_match err=%b expected=0", err);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick();
            checks++;
            if ({m_chipselect, m_write_n, ack0, ack1, busy, err, m_address, m_writedata} !== {exp_ctl(), m_addr, m_data}) begin
                failures++;
                $display("FAIL random_cycle c=%0d actual=%b_%h expected=%b_%h", c, {m_chipselect, m_write_n, ack0, ack1, busy, err}, {m_address, m_writedata}, exp_ctl(), {m_addr, m_data});
            end
            if (req0 && ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; addr0 = 2'($urandom()); data0 = $urandom();
            end
            if (req1 && ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; addr1 = 2'($urandom()); data1 = $urandom();
            end
            m_readdata = $urandom();
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_drop_mid();
        test_reset_mid();
        test_verify();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
